// File: rtl/pipelined_addsub32.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipelined_addsub32
//
// Two-stage pipelined 32-bit adder/subtractor for the ALU datapath. The sum is
// built from 4-bit carry-lookahead groups whose group generate/propagate terms
// feed a second-level lookahead. The carry chain is cut at bit SPLIT: stage 1
// produces the low sum bits and the carry into bit SPLIT, stage 2 finishes the
// upper bits from the registered operands and that carry.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   block accepts a beat this cycle (combinational)
//   a, b       operands
//   sub        1: a - b, 0: a + b
//   out_valid  result beat offered
//   out_ready  consumer accepts the result
//   result     sum or difference
//   cout       carry out of the MSB (for subtract, 1 means no borrow)
//   overflow   signed overflow
//   zero       result == 0
//   negative   result MSB
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. A producer holding valid keeps its data stable
// until that edge; ready never depends on the producer's valid.
// -----------------------------------------------------------------------------
module pipelined_addsub32 #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int HW = WIDTH - SPLIT;  // width of the upper half
    localparam int NG = WIDTH / 4;      // total number of 4-bit groups
    localparam int LG = SPLIT / 4;      // groups belonging to stage 1

    // Carry out of groups [lo, hi) given the carry into group lo, written as a
    // flat sum of products so every group carry is two levels deep.
    function automatic logic la_carry(input logic [NG-1:0] ggen,
                                      input logic [NG-1:0] gprop,
                                      input logic          ci,
                                      input int            lo,
                                      input int            hi);
        logic acc;
        logic term;
        acc = ci;
        for (int m = lo; m < hi; m++) acc = acc & gprop[m];
        for (int j = lo; j < hi; j++) begin
            term = ggen[j];
            for (int m = j + 1; m < hi; m++) term = term & gprop[m];
            acc = acc | term;
        end
        return acc;
    endfunction

    // Subtraction is a + ~b + 1.
    logic [WIDTH-1:0] bx;
    assign bx = b ^ {WIDTH{sub}};

    // Stage 1 registers
    logic             s1_valid;
    logic [SPLIT-1:0] s1_sum_lo;
    logic             s1_c16;
    logic [HW-1:0]    s1_a_hi;
    logic [HW-1:0]    s1_bx_hi;

    // One operand view across the full width: the low groups see the live
    // inputs (stage 1), the high groups see the registered upper halves
    // (stage 2). No group straddles the cut because SPLIT is a multiple of 4.
    logic [WIDTH-1:0] x_all;
    logic [WIDTH-1:0] y_all;
    assign x_all = {s1_a_hi, a[SPLIT-1:0]};
    assign y_all = {s1_bx_hi, bx[SPLIT-1:0]};

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    assign g = x_all & y_all;
    assign p = x_all ^ y_all;

    logic [NG-1:0]    gg;       // group generate
    logic [NG-1:0]    gp;       // group propagate
    logic [NG-1:0]    gci;      // carry into each group
    logic             lo_cout;  // carry into bit SPLIT
    logic             hi_cout;  // carry out of the MSB
    logic [WIDTH-1:0] c;        // carry into each bit
    logic [WIDTH-1:0] sum_all;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int i = 0; i < NG; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
    end

    // Second-level lookahead, run independently for each side of the cut.
    always_comb begin
        gci = '0;
        for (int i = 0; i < LG; i++) gci[i] = la_carry(gg, gp, sub, 0, i);
        lo_cout = la_carry(gg, gp, sub, 0, LG);
        for (int i = LG; i < NG; i++) gci[i] = la_carry(gg, gp, s1_c16, LG, i);
        hi_cout = la_carry(gg, gp, s1_c16, LG, NG);
    end

    // In-group lookahead from each group's carry-in.
    always_comb begin
        c = '0;
        for (int i = 0; i < NG; i++) begin
            c[4*i]   = gci[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gci[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & gci[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gci[i]);
        end
    end

    assign sum_all = p ^ c;

    // Flow control
    logic s2_load;
    logic accept;
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    logic [WIDTH-1:0] next_result;
    assign next_result = {sum_all[WIDTH-1:SPLIT], s1_sum_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sum_lo <= '0;
            s1_c16    <= 1'b0;
            s1_a_hi   <= '0;
            s1_bx_hi  <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_sum_lo <= sum_all[SPLIT-1:0];
            s1_c16    <= lo_cout;
            s1_a_hi   <= a[WIDTH-1:SPLIT];
            s1_bx_hi  <= bx[WIDTH-1:SPLIT];
        end else if (s1_valid && s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (s1_valid && s2_load) begin
            out_valid <= 1'b1;
            result    <= next_result;
            cout      <= hi_cout;
            // Signed overflow: carry into the MSB differs from carry out.
            overflow  <= c[WIDTH-1] ^ hi_cout;
            zero      <= ~|next_result;
            negative  <= next_result[WIDTH-1];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub32.sv
`timescale 1ns/1ps
module tb_pipelined_addsub32;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;
    logic        negative;

    int n_checks = 0;
    int n_fail   = 0;
    bit drv_done = 1'b0;

    // {cout, overflow, zero, negative, result}
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_addsub32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain 33-bit arithmetic and the signed-overflow sign rule.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [32:0] full;
        logic [31:0] r;
        logic        v;
        if (s) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
        else   full = {1'b0, x} + {1'b0, y};
        r = full[31:0];
        if (s) v = (x[31] != y[31]) && (r[31] != x[31]);
        else   v = (x[31] == y[31]) && (r[31] != x[31]);
        return {full[32], v, (r == 32'd0), r[31], r};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("idle_out_valid", out_valid, 0);
            end else if (out_valid) begin
                check_val("out_beat", {cout, overflow, zero, negative, result}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] x, input logic [31:0] y, input logic s, output logic ok);
        int w;
        w = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        while (!ok && w < 200) begin
            @(negedge clk);
            ok = in_ready;
            cyc();
            w++;
        end
        in_valid = 1'b0;
    endtask

    // One beat into an empty pipeline: out_valid must rise exactly two
    // clock edges after the cycle in which the beat is offered.
    task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic s,
                            input logic [31:0] er, input logic [3:0] ef);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        @(negedge clk);
        check_val("dir_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        check_val("dir_latency_edge1", out_valid, 0);
        cyc();
        check_val("dir_latency_edge2", out_valid, 1);
        check_val("dir_result", result, er);
        check_val("dir_flags_cvzn", {cout, overflow, zero, negative}, ef);
        cyc();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_FFFF;
            5: return 32'hFFFF_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic        ok;
        logic        acc;
        int          idx;
        logic [31:0] bp_exp[9];
        bp_exp = '{32'd0, 32'd0, 32'd2, 32'd2, 32'd2, 32'd4, 32'd6, 32'd0, 32'd0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;

        #12;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result", result, 0);
        check_val("rst_flags", {cout, overflow, zero, negative}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        cyc();

        // Directed arithmetic and boundary cases; flags = {cout, ovf, zero, neg}
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
        directed(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 4'b0001);
        directed(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 4'b1000);
        directed(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);
        directed(32'h8000_FFFF, 32'h8000_0001, 1'b0, 32'h0001_0000, 4'b1100);
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100);
        directed(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010);

        // Backpressure: out_ready low for 4 cycles while offering 1+1, 2+2, 3+3
        idx = 0;
        for (int cy = 0; cy < 9; cy++) begin
            out_ready = (cy >= 4);
            if (idx < 3) begin
                in_valid = 1'b1;
                a = 32'(idx + 1);
                b = 32'(idx + 1);
                sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cy < 2) check_val("bp_in_ready_open", in_ready, 1);
            if (cy == 2 || cy == 3) check_val("bp_in_ready_full", in_ready, 0);
            if (cy >= 2 && cy <= 6) begin
                check_val("bp_out_valid", out_valid, 1);
                check_val("bp_result", result, bp_exp[cy]);
            end
            if (cy >= 7) check_val("bp_out_idle", out_valid, 0);
            acc = in_valid && in_ready;
            cyc();
            if (acc) idx++;
        end

        // Reset with one beat in flight
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h0000_0001;
        sub = 1'b0;
        cyc();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_result", result, 0);
        check_val("midrst_flags", {cout, overflow, zero, negative}, 0);
        check_val("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check_val("postrst_in_ready", in_ready, 1);
            check_val("postrst_no_output", out_valid, 0);
        end
        cyc();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) cyc();
                    drive_beat(pick(), pick(), 1'($urandom_range(0, 1)), ok);
                    check_val("rand_accept_wait", ok, 1);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
            end
        join

        out_ready = 1'b1;
        for (int w = 0; w < 500 && exp_q.size() != 0; w++) cyc();
        check_val("drain_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
